// File: rtl/sample_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sample_scheduler_if -- EBI register bus plus unit-sample and FIFO signals
// Revision 1.0
// ----------------------------------------------------------------------------
interface sample_scheduler_if;
   logic [18:0] addr;
   logic [15:0] ebi_data_in;
   logic [15:0] ebi_data_out;
   logic        cs;
   logic        re;
   logic        wr;
   logic [7:0]  channel_select;
   logic        output_sample;
   logic [15:0] sample_data;
   logic        fifo_full;
   logic        fifo_wr;
   logic [15:0] fifo_din;
   logic        busy;

   modport master (
      output addr, ebi_data_in, cs, re, wr, sample_data, fifo_full,
      input  ebi_data_out, channel_select, output_sample, fifo_wr, fifo_din, busy
   );

   modport slave (
      input  addr, ebi_data_in, cs, re, wr, sample_data, fifo_full,
      output ebi_data_out, channel_select, output_sample, fifo_wr, fifo_din, busy
   );
endinterface
`default_nettype wire

// File: rtl/sample_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sample_scheduler -- periodic sweep over an EBI-programmed channel list, one sample per unit into a FIFO
// Revision 1.0
// ----------------------------------------------------------------------------
module sample_scheduler #(
   parameter int POSITION  = 243,
   parameter int MAX_UNITS = 16
) (
   input  wire logic         clk,
   input  wire logic         rst,
   sample_scheduler_if.slave bus
);
   localparam int               CNT_W      = $clog2(MAX_UNITS + 1);
   localparam int               LIST_DEPTH = 2 ** CNT_W;
   localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_UNITS);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SELECT  = 3'd1,
      STROBE  = 3'd2,
      CAPTURE = 3'd3,
      WRITE   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [7:0]       list [LIST_DEPTH];
   logic [CNT_W-1:0] num_units;
   logic [CNT_W-1:0] idx;
   logic             run;
   logic [15:0]      period;
   logic [15:0]      period_cnt;
   logic [15:0]      drop_count;
   logic [15:0]      miss_count;
   logic [15:0]      sample_reg;
   logic [15:0]      read_data;
   logic [15:0]      ebi_out_reg;
   logic [7:0]       channel_reg;
   logic             wr_d;
   logic             selected;
   logic             write_en;
   logic             clear;
   logic             tick;
   logic             last_unit;

   assign selected  = bus.cs && (bus.addr[18:8] == 11'(POSITION));
   assign write_en  = selected && bus.wr && !wr_d;
   assign clear     = write_en && (bus.addr[7:0] == 8'd1);
   assign tick      = run && (period_cnt == period);
   // Live num_units lets entries appended mid-sweep still be visited.
   assign last_unit = ((CNT_W+1)'(idx) + (CNT_W+1)'(1)) >= (CNT_W+1)'(num_units);

   assign bus.output_sample  = (state == STROBE);
   assign bus.fifo_wr        = (state == WRITE) && !bus.fifo_full;
   assign bus.busy           = (state != IDLE);
   assign bus.fifo_din       = sample_reg;
   assign bus.channel_select = channel_reg;
   assign bus.ebi_data_out   = ebi_out_reg;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (tick && (num_units != '0)) state_next = SELECT;
         SELECT:  state_next = STROBE;
         STROBE:  state_next = CAPTURE;
         CAPTURE: state_next = WRITE;
         WRITE:   state_next = last_unit ? IDLE : SELECT;
         default: state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   always_comb begin
      read_data = '0;
      case (bus.addr[7:0])
         8'd2:    read_data = {15'd0, run};
         8'd4:    read_data = 16'(num_units);
         8'd5:    read_data = drop_count;
         8'd6:    read_data = miss_count;
         default: read_data = '0;
      endcase
   end

   // List storage carries no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (write_en && (bus.addr[7:0] == 8'd0) && (num_units != MAX_CNT))
         list[num_units] <= bus.ebi_data_in[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_d        <= 1'b0;
         num_units   <= '0;
         idx         <= '0;
         run         <= 1'b0;
         period      <= '0;
         period_cnt  <= '0;
         drop_count  <= '0;
         miss_count  <= '0;
         sample_reg  <= '0;
         channel_reg <= '0;
         ebi_out_reg <= '0;
      end else begin
         wr_d <= bus.wr;

         if (write_en) begin
            case (bus.addr[7:0])
               8'd0:    if (num_units != MAX_CNT) num_units <= num_units + CNT_W'(1);
               8'd1:    num_units <= '0;
               8'd2:    run <= bus.ebi_data_in[0];
               8'd3:    period <= bus.ebi_data_in;
               default: ;
            endcase
         end

         if (write_en && (bus.addr[7:0] == 8'd3)) period_cnt <= '0;
         else if (!run || (period_cnt >= period)) period_cnt <= '0;
         else period_cnt <= period_cnt + 16'd1;

         if (clear || (state == IDLE)) idx <= '0;
         else if (state == WRITE)      idx <= last_unit ? '0 : idx + CNT_W'(1);

         if (state == SELECT)  channel_reg <= list[idx];
         if (state == CAPTURE) sample_reg  <= bus.sample_data;

         if ((state == WRITE) && bus.fifo_full && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
         if (tick && (state != IDLE) && (miss_count != 16'hFFFF))
            miss_count <= miss_count + 16'd1;

         if (selected && bus.re) ebi_out_reg <= read_data;
      end
   end
endmodule
`default_nettype wire
